// File: rtl/cascade_pkg.sv
// Shared definitions for the Haar cascade sequencer.
// Holds the default cascade dimensions, the sequencer state encoding and a
// width helper used to derive the stage, node and address widths.
package cascade_pkg;

  localparam int DEF_NUM_STAGES  = 22;
  localparam int DEF_MAX_NODES   = 255;
  localparam int DEF_TOTAL_NODES = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_t;

  // $clog2 with a floor of one bit, so a single-stage cascade still gets a
  // legal (1-bit) stage index instead of a zero-width vector.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cascade_node_counter.sv
// Node address / in-stage index counters for the cascade sequencer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        new window: node_addr and node_idx return to 0
//   next_stage   new stage: node_idx returns to 0, node_addr keeps counting
//   load         latch count_in as the node count of the current stage
//   count_in     node count of the current stage
//   advance      one node accepted: node_addr and node_idx step by one
//   node_addr    global node index (wraps modulo 2^AW)
//   node_idx     node index within the current stage
//   last         node_idx is the final node of the latched count
module cascade_node_counter import cascade_pkg::*; #(
  parameter int NW = 8,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          next_stage,
  input  logic          load,
  input  logic [NW-1:0] count_in,
  input  logic          advance,
  output logic [AW-1:0] node_addr,
  output logic [NW-1:0] node_idx,
  output logic          last
);

  logic [AW-1:0] addr_reg;
  logic [NW-1:0] idx_reg;
  logic [NW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      idx_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      if (start) begin
        addr_reg <= '0;
        idx_reg  <= '0;
      end else if (next_stage) begin
        idx_reg  <= '0;
      end else if (advance) begin
        addr_reg <= addr_reg + AW'(1);
        idx_reg  <= idx_reg + NW'(1);
      end
      if (load) begin
        cnt_reg <= count_in;
      end
    end
  end

  // Compare idx+1 against the count one bit wider so a count of zero never
  // aliases to "last" through an underflowing cnt-1.
  assign last      = (({1'b0, idx_reg} + {{NW{1'b0}}, 1'b1}) == {1'b0, cnt_reg});
  assign node_addr = addr_reg;
  assign node_idx  = idx_reg;

endmodule

// File: rtl/cascade_sequencer.sv
// Stage/node sequencer for the Haar cascade classifier.
// Takes one candidate window at a time, walks the stages, issues each node
// of the current stage to the feature/accumulator datapath (stallable), waits
// for the stage verdict and either moves on, rejects early, or declares a face.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   abort               synchronous abandon of the current window
//   win_valid/win_ready window handshake (ready only while idle)
//   stage_idx           current stage, addresses the external node-count table
//   stage_nodes         node count of stage_idx (combinational lookup)
//   node_valid/ready    node issue handshake; node_addr = ROM address,
//   node_addr, node_idx node_idx = index within stage
//   acc_clear           one-cycle pulse that clears the stage accumulator
//   stage_result_valid  stage verdict strobe, stage_pass = verdict
//   result_valid/ready  decision handshake; result_face = all stages passed,
//   result_face         result_stage = last stage evaluated
//   result_stage
module cascade_sequencer import cascade_pkg::*; #(
  parameter  int NUM_STAGES  = DEF_NUM_STAGES,
  parameter  int MAX_NODES   = DEF_MAX_NODES,
  parameter  int TOTAL_NODES = DEF_TOTAL_NODES,
  localparam int SW          = width_of(NUM_STAGES),
  localparam int NW          = width_of(MAX_NODES + 1),
  localparam int AW          = width_of(TOTAL_NODES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          win_valid,
  output logic          win_ready,
  output logic [SW-1:0] stage_idx,
  input  logic [NW-1:0] stage_nodes,
  output logic          node_valid,
  input  logic          node_ready,
  output logic [AW-1:0] node_addr,
  output logic [NW-1:0] node_idx,
  output logic          acc_clear,
  input  logic          stage_result_valid,
  input  logic          stage_pass,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          result_face,
  output logic [SW-1:0] result_stage
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  seq_state_t state_reg, state_next;

  logic [SW-1:0] stage_idx_reg;
  logic          acc_clear_reg;
  logic          result_valid_reg;
  logic          result_face_reg;
  logic [SW-1:0] result_stage_reg;

  logic accept;
  logic stage_inc;
  logic advance;
  logic finish;
  logic face_next;
  logic load_count;
  logic last_node;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    stage_inc  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    face_next  = 1'b0;
    load_count = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          accept     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_count = 1'b1;
        // An empty stage still produces a verdict, so go straight to WAIT.
        state_next = (stage_nodes == '0) ? ST_WAIT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (node_ready) begin
          advance = 1'b1;
          if (last_node) begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (stage_result_valid) begin
          if (!stage_pass) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end else if (stage_idx_reg == LAST_STAGE) begin
            finish     = 1'b1;
            face_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            stage_inc  = 1'b1;
            state_next = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides everything outside IDLE and suppresses every side
    // effect of the cycle, including the accumulator clear.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      accept     = 1'b0;
      stage_inc  = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      face_next  = 1'b0;
      load_count = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      stage_idx_reg    <= '0;
      acc_clear_reg    <= 1'b0;
      result_valid_reg <= 1'b0;
      result_face_reg  <= 1'b0;
      result_stage_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        stage_idx_reg <= '0;
      end else if (stage_inc) begin
        stage_idx_reg <= stage_idx_reg + SW'(1);
      end
      // Registered decodes of the next state keep these outputs glitch-free.
      acc_clear_reg    <= (state_next == ST_LOAD);
      result_valid_reg <= (state_next == ST_DONE);
      if (finish) begin
        result_face_reg  <= face_next;
        result_stage_reg <= stage_idx_reg;
      end
    end
  end

  cascade_node_counter #(
    .NW(NW),
    .AW(AW)
  ) u_node_counter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .next_stage(stage_inc),
    .load      (load_count),
    .count_in  (stage_nodes),
    .advance   (advance),
    .node_addr (node_addr),
    .node_idx  (node_idx),
    .last      (last_node)
  );

  assign win_ready    = (state_reg == ST_IDLE);
  assign node_valid   = (state_reg == ST_ISSUE);
  assign stage_idx    = stage_idx_reg;
  assign acc_clear    = acc_clear_reg;
  assign result_valid = result_valid_reg;
  assign result_face  = result_face_reg;
  assign result_stage = result_stage_reg;

endmodule

// File: tb/tb_cascade_sequencer.sv
// Directed bench for cascade_sequencer with a 3-stage cascade.
// The bench plays the node-count ROM and the stage accumulator: it returns a
// verdict two cycles after the last node of a stage has been accepted.
module tb_cascade_sequencer;
  import cascade_pkg::*;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        win_valid;
  logic        win_ready;
  logic [1:0]  stage_idx;
  logic [7:0]  stage_nodes;
  logic        node_valid;
  logic        node_ready;
  logic [11:0] node_addr;
  logic [7:0]  node_idx;
  logic        acc_clear;
  logic        stage_result_valid;
  logic        stage_pass;
  logic        result_valid;
  logic        result_ready;
  logic        result_face;
  logic [1:0]  result_stage;

  int counts [NS];

  always_comb begin
    stage_nodes = 8'd0;
    if (int'(stage_idx) < NS) stage_nodes = 8'(counts[stage_idx]);
  end

  always #5 clk = ~clk;

  cascade_sequencer #(
    .NUM_STAGES (NS),
    .MAX_NODES  (255),
    .TOTAL_NODES(4095)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .abort             (abort),
    .win_valid         (win_valid),
    .win_ready         (win_ready),
    .stage_idx         (stage_idx),
    .stage_nodes       (stage_nodes),
    .node_valid        (node_valid),
    .node_ready        (node_ready),
    .node_addr         (node_addr),
    .node_idx          (node_idx),
    .acc_clear         (acc_clear),
    .stage_result_valid(stage_result_valid),
    .stage_pass        (stage_pass),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .result_face       (result_face),
    .result_stage      (result_stage)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Per-window observations filled in by run_window.
  int addr_log [$];
  int idx_err, clr_cnt, max_stage, nv_stage1, stall_err, stall_cnt, hold_err;
  int got_face, got_stage;
  bit timed_out, aborted;

  // Number of logged addresses that do not equal their position (0,1,2,..).
  function automatic int contig_err();
    int e = 0;
    foreach (addr_log[i]) if (addr_log[i] != i) e++;
    return e;
  endfunction

  // Runs one window from IDLE. Call #1 after a rising edge.
  // fail_stage: stage whose verdict is "fail" (-1 = none)
  // toggle_s0 : node_ready alternates 1,0,1,.. during stage 0 issue
  // rr_hold   : cycles result_ready is held low while result_valid is up
  // abort_mode: 0 none, 1 abort after first node of stage 0, 2 abort in DONE
  task automatic run_window(input int fail_stage, input bit toggle_s0,
                            input int rr_hold, input int abort_mode);
    int issued = 0, cnt_now = 0, wait_cyc = 0, cur_stage = 0, s0_cyc = 0, held = 0;
    bit pending = 0, prev_stall = 0;
    logic [11:0] prev_addr = '0;
    logic snap_face = 1'b0;
    logic [1:0] snap_stage = '0;
    addr_log.delete();
    idx_err = 0; clr_cnt = 0; max_stage = 0; nv_stage1 = 0;
    stall_err = 0; stall_cnt = 0; hold_err = 0;
    got_face = -1; got_stage = -1; timed_out = 0; aborted = 0;
    win_valid = 1'b1; node_ready = 1'b1; result_ready = 1'b0;
    stage_result_valid = 1'b0; stage_pass = 1'b0; abort = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      stage_result_valid = 1'b0;
      if (!win_ready) win_valid = 1'b0;
      if (prev_stall && node_addr !== prev_addr) stall_err++;
      if (acc_clear) begin
        clr_cnt++;
        cur_stage = int'(stage_idx);
        cnt_now = counts[stage_idx];
        if (cur_stage > max_stage) max_stage = cur_stage;
        issued = 0; pending = 1; wait_cyc = 0;
      end
      if (node_valid && stage_idx == 2'd1) nv_stage1++;
      node_ready = 1'b1;
      if (toggle_s0 && node_valid && cur_stage == 0) begin
        node_ready = (s0_cyc % 2 == 0);
        s0_cyc++;
      end
      if (abort_mode == 1 && node_valid && issued == 1) begin
        abort = 1'b1; node_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0; aborted = 1;
        return;
      end
      prev_stall = node_valid && !node_ready;
      if (prev_stall) stall_cnt++;
      prev_addr = node_addr;
      if (node_valid && node_ready) begin
        addr_log.push_back(int'(node_addr));
        if (int'(node_idx) != issued) idx_err++;
        issued++;
      end
      if (pending && !acc_clear && !node_valid && !result_valid && issued == cnt_now) begin
        wait_cyc++;
        if (wait_cyc == 2) begin
          stage_result_valid = 1'b1;
          stage_pass = (cur_stage != fail_stage);
          pending = 0;
        end
      end
      if (result_valid) begin
        if (held == 0) begin
          snap_face = result_face; snap_stage = result_stage;
        end else if (result_face !== snap_face || result_stage !== snap_stage || win_ready !== 1'b0) begin
          hold_err++;
        end
        if (abort_mode == 2) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0; aborted = 1;
          return;
        end
        if (held >= rr_hold) begin
          result_ready = 1'b1;
          got_face = int'(result_face); got_stage = int'(result_stage);
          @(posedge clk); #1;
          result_ready = 1'b0;
          $display("[win] nodes=%0d clears=%0d face=%0d stage=%0d hold=%0d",
                   addr_log.size(), clr_cnt, got_face, got_stage, held);
          return;
        end
        held++;
      end
    end
    timed_out = 1;
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; win_valid = 1'b0; node_ready = 1'b0;
    stage_result_valid = 1'b0; stage_pass = 1'b0; result_ready = 1'b0;
    counts = '{2, 3, 1};

    // Reset values
    #12;
    check("rst_win_ready", int'(win_ready), 1);
    check("rst_node_valid", int'(node_valid), 0);
    check("rst_acc_clear", int'(acc_clear), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_stage_idx", int'(stage_idx), 0);
    check("rst_node_addr", int'(node_addr), 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // 1: all stages pass
    run_window(-1, 1'b0, 0, 0);
    check("t1_timeout", int'(timed_out), 0);
    check("t1_nodes", addr_log.size(), 6);
    check("t1_contig", contig_err(), 0);
    check("t1_node_idx", idx_err, 0);
    check("t1_clears", clr_cnt, 3);
    check("t1_face", got_face, 1);
    check("t1_stage", got_stage, 2);
    check("t1_win_ready_after", int'(win_ready), 1);
    check("t1_result_valid_after", int'(result_valid), 0);

    // 2: stage 1 fails, stage 2 never loaded
    run_window(1, 1'b0, 0, 0);
    check("t2_timeout", int'(timed_out), 0);
    check("t2_nodes", addr_log.size(), 5);
    check("t2_contig", contig_err(), 0);
    check("t2_clears", clr_cnt, 2);
    check("t2_max_stage", max_stage, 1);
    check("t2_face", got_face, 0);
    check("t2_stage", got_stage, 1);

    // 3: node_ready toggling in stage 0
    run_window(-1, 1'b1, 0, 0);
    check("t3_timeout", int'(timed_out), 0);
    check("t3_nodes", addr_log.size(), 6);
    check("t3_contig", contig_err(), 0);
    check("t3_stall_hold", stall_err, 0);
    check("t3_stalls", stall_cnt, 1);
    check("t3_node_idx", idx_err, 0);

    // 4: empty stage 1
    counts = '{2, 0, 1};
    run_window(-1, 1'b0, 0, 0);
    check("t4_timeout", int'(timed_out), 0);
    check("t4_nodes", addr_log.size(), 3);
    check("t4_contig", contig_err(), 0);
    check("t4_clears", clr_cnt, 3);
    check("t4_no_issue_s1", nv_stage1, 0);
    check("t4_face", got_face, 1);
    check("t4_stage", got_stage, 2);
    counts = '{2, 3, 1};

    // 5a: abort during ISSUE
    run_window(-1, 1'b0, 0, 1);
    check("t5a_aborted", int'(aborted), 1);
    check("t5a_win_ready", int'(win_ready), 1);
    check("t5a_node_valid", int'(node_valid), 0);
    check("t5a_acc_clear", int'(acc_clear), 0);
    check("t5a_result_valid", int'(result_valid), 0);
    // recovery: next window starts from address 0
    run_window(-1, 1'b0, 0, 0);
    check("t5a_recover_nodes", addr_log.size(), 6);
    check("t5a_recover_contig", contig_err(), 0);
    check("t5a_recover_face", got_face, 1);

    // 5b: abort in DONE with result_ready low
    run_window(-1, 1'b0, 5, 2);
    check("t5b_aborted", int'(aborted), 1);
    check("t5b_win_ready", int'(win_ready), 1);
    check("t5b_result_valid", int'(result_valid), 0);
    check("t5b_acc_clear", int'(acc_clear), 0);
    @(posedge clk); #1;
    check("t5b_result_dropped", int'(result_valid), 0);

    // 6: result_ready held low for 10 cycles
    run_window(0, 1'b0, 10, 0);
    check("t6_timeout", int'(timed_out), 0);
    check("t6_hold_stable", hold_err, 0);
    check("t6_face", got_face, 0);
    check("t6_stage", got_stage, 0);
    check("t6_win_ready_after", int'(win_ready), 1);
    check("t6_result_valid_after", int'(result_valid), 0);

    // 6b: asynchronous reset in the middle of ISSUE
    win_valid = 1'b1; node_ready = 1'b1;
    begin
      bit reached = 0;
      for (int c = 0; c < 20 && !reached; c++) begin
        @(posedge clk); #1;
        if (!win_ready) win_valid = 1'b0;
        if (node_valid && node_idx == 8'd1) reached = 1;
      end
      check("t6b_reached_issue", int'(reached), 1);
    end
    check("t6b_pre_addr", int'(node_addr), 1);
    #2 rst = 1'b1;
    #1;
    check("t6b_win_ready", int'(win_ready), 1);
    check("t6b_node_valid", int'(node_valid), 0);
    check("t6b_node_addr", int'(node_addr), 0);
    check("t6b_node_idx", int'(node_idx), 0);
    check("t6b_acc_clear", int'(acc_clear), 0);
    check("t6b_result_valid", int'(result_valid), 0);
    check("t6b_result_face", int'(result_face), 0);
    check("t6b_stage_idx", int'(stage_idx), 0);
    check("t6b_result_stage", int'(result_stage), 0);
    #10 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6b_no_result", int'(result_valid), 0);
    check("t6b_idle", int'(win_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
